// File: rtl/pipe_flow_pkg.sv
// Flow-control helpers for the fixed-latency data/status pipe.
// The upstream launcher imports this package so both ends compute the same stop threshold.
package pipe_flow_pkg;

   // Occupancy at which stop_o rises so that every beat still in flight fits.
   function automatic int unsigned stop_thresh(input int unsigned depth,
                                               input int unsigned pipe_depth);
      return depth - pipe_depth - 1;
   endfunction

   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/data_status_pipe_sink_wrap_ptr.sv
// Modulo-DEPTH pointer with increment enable; DEPTH need not be a power of two.
module wrap_ptr #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);

   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
      end
   end

endmodule

// File: rtl/data_status_pipe_sink.sv
// Receiving end of a no-backpressure fixed-latency pipe: show-ahead circular FIFO
// that raises stop_o early enough for every in-flight beat to land.
module data_status_pipe_sink
   import pipe_flow_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STATUS_W   = 1,
   parameter int unsigned PIPE_DEPTH = 1,
   parameter int unsigned DEPTH      = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        valid_i,
   input  logic [DATA_W-1:0]           data_i,
   input  logic [STATUS_W-1:0]         status_i,
   output logic                        stop_o,
   output logic                        valid_o,
   input  logic                        ready_i,
   output logic [DATA_W-1:0]           data_o,
   output logic [STATUS_W-1:0]         status_o,
   output logic [cnt_w(DEPTH)-1:0]     count_o,
   output logic                        overflow_o
);

   localparam int unsigned CNT_W       = cnt_w(DEPTH);
   localparam int unsigned PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned ENTRY_W     = STATUS_W + DATA_W;
   localparam int unsigned STOP_THRESH = stop_thresh(DEPTH, PIPE_DEPTH);

   if (DEPTH < PIPE_DEPTH + 2) begin : g_depth_check
      $error("data_status_pipe_sink: DEPTH must be >= PIPE_DEPTH+2");
   end

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [ENTRY_W-1:0] head;
   logic [CNT_W-1:0]   count;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               push;
   logic               pop;

   // A full FIFO still accepts a beat when the head leaves in the same cycle.
   assign pop  = valid_o & ready_i;
   assign push = valid_i & ((count < CNT_W'(DEPTH)) | pop);

   wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .inc (push),
      .ptr (wr_ptr)
   );

   wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .inc (pop),
      .ptr (rd_ptr)
   );

   // Payload storage; intentionally not reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {status_i, data_i};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count      <= '0;
         overflow_o <= 1'b0;
      end else begin
         count <= count + CNT_W'(push) - CNT_W'(pop);
         if (valid_i & ~push) begin
            overflow_o <= 1'b1;
         end
      end
   end

   assign head     = mem[rd_ptr];
   assign data_o   = head[DATA_W-1:0];
   assign status_o = head[ENTRY_W-1:DATA_W];
   assign valid_o  = (count != '0);
   assign stop_o   = (count >= CNT_W'(STOP_THRESH));
   assign count_o  = count;

endmodule

// File: tb/tb_data_status_pipe_sink.sv
// Directed bench for data_status_pipe_sink with a 2-stage upstream launcher model
// and a queue reference of the FIFO contents.
module tb_data_status_pipe_sink;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid_i;
   logic [7:0] data_i;
   logic [1:0] status_i;
   logic       stop_o;
   logic       valid_o;
   logic       ready_i;
   logic [7:0] data_o;
   logic [1:0] status_o;
   logic [2:0] count_o;
   logic       overflow_o;

   int n_chk = 0;
   int n_err = 0;

   data_status_pipe_sink #(
      .DATA_W(8), .STATUS_W(2), .PIPE_DEPTH(2), .DEPTH(6)
   ) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i), .status_i(status_i),
      .stop_o(stop_o), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
      .status_o(status_o), .count_o(count_o), .overflow_o(overflow_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] st(input logic [7:0] d);
      return d[1:0] ^ d[3:2];
   endfunction

   // Reference contents: {status, data} per entry, plus sticky drop flag.
   logic [9:0] q[$];
   logic       m_ovf;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         m_ovf = 1'b0;
      end else begin
         logic m_pop, m_push;
         m_pop  = (q.size() != 0) && ready_i;
         m_push = valid_i && ((q.size() < 6) || m_pop);
         if (valid_i && !m_push) m_ovf = 1'b1;
         if (m_pop) void'(q.pop_front());
         if (m_push) q.push_back({status_i, data_i});
      end
   end

   // Upstream launcher: stop_o is registered, then the beat crosses two stages.
   logic       use_up, up_want, up_stop_prev, up_stop_q;
   logic       up_l_v, up_s1_v, up_s2_v;
   logic [7:0] up_l_d, up_s1_d, up_s2_d, up_base;
   int         up_cnt, up_lim;
   logic       man_v, rdy;
   logic [7:0] man_d;
   logic [1:0] man_s;

   task automatic cyc();
      @(negedge clk);
      up_s2_v = up_s1_v; up_s2_d = up_s1_d;
      up_s1_v = up_l_v;  up_s1_d = up_l_d;
      up_stop_q = up_stop_prev;
      if (use_up && up_want && !up_stop_q && up_cnt < up_lim) begin
         up_l_v = 1'b1;
         up_l_d = up_base + 8'(up_cnt);
         up_cnt++;
      end else begin
         up_l_v = 1'b0;
      end
      up_stop_prev = stop_o;
      valid_i  = use_up ? up_s2_v : man_v;
      data_i   = use_up ? up_s2_d : man_d;
      status_i = use_up ? st(up_s2_d) : man_s;
      ready_i  = rdy;
      chk("m_count", count_o, q.size());
      chk("m_valid", valid_o, q.size() != 0);
      chk("m_stop", stop_o, q.size() >= 3);
      chk("m_ovf", overflow_o, m_ovf);
      if (q.size() != 0) begin
         chk("m_data", data_o, q[0][7:0]);
         chk("m_status", status_o, q[0][9:8]);
      end
   endtask

   int         k;
   logic       seen, prev_stop;
   logic [7:0] exp_full [6];

   initial begin
      rst = 1'b1; valid_i = 1'b0; data_i = '0; status_i = '0; ready_i = 1'b0;
      use_up = 1'b0; up_want = 1'b0; up_stop_prev = 1'b0; up_stop_q = 1'b0;
      up_l_v = 1'b0; up_s1_v = 1'b0; up_s2_v = 1'b0;
      up_l_d = '0; up_s1_d = '0; up_s2_d = '0; up_base = '0; up_cnt = 0; up_lim = 0;
      man_v = 1'b0; man_d = '0; man_s = '0; rdy = 1'b0;
      exp_full = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h30};
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Idle after reset
      repeat (3) cyc();
      chk("rst_valid", valid_o, 0);
      chk("rst_stop", stop_o, 0);
      chk("rst_count", count_o, 0);
      chk("rst_ovf", overflow_o, 0);

      // Single push, head held stable
      man_v = 1'b1; man_d = 8'hA1; man_s = 2'b01;
      cyc();
      man_v = 1'b0;
      cyc();
      chk("one_valid", valid_o, 1);
      chk("one_data", data_o, 8'hA1);
      chk("one_status", status_o, 1);
      chk("one_count", count_o, 1);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("hold_data", data_o, 8'hA1);
      end
      rdy = 1'b1; cyc();
      rdy = 1'b0; cyc();
      chk("one_drained", count_o, 0);

      // Fill through the upstream model with ready low
      use_up = 1'b1; up_want = 1'b1; up_base = 8'h10; up_cnt = 0; up_lim = 6; seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (stop_o && !seen) begin
            seen = 1'b1;
            chk("stop_rise_cnt", count_o, 3);
         end
      end
      chk("fill_count", count_o, 6);
      chk("fill_stop", stop_o, 1);
      chk("fill_ovf", overflow_o, 0);

      // Drain in order; stop falls at count 2
      up_want = 1'b0; rdy = 1'b1; k = 0; prev_stop = 1'b1;
      for (int i = 0; i < 20 && k < 6; i++) begin
         cyc();
         if (prev_stop && !stop_o) chk("stop_fall_cnt", count_o, 2);
         prev_stop = stop_o;
         if (valid_o && ready_i) begin
            chk("drain_data", data_o, 8'h10 + 8'(k));
            k++;
         end
      end
      chk("drain_n", k, 6);
      rdy = 1'b0; cyc();
      chk("drain_empty", valid_o, 0);

      // Full: simultaneous push/pop, then a dropped beat
      up_want = 1'b1; up_base = 8'h20; up_cnt = 0; up_lim = 6;
      repeat (20) cyc();
      chk("full2_count", count_o, 6);
      use_up = 1'b0;
      man_v = 1'b1; man_d = 8'h30; man_s = st(8'h30); rdy = 1'b1;
      cyc();
      man_d = 8'h31; man_s = st(8'h31); rdy = 1'b0;
      cyc();
      chk("pp_count", count_o, 6);
      chk("pp_ovf", overflow_o, 0);
      man_v = 1'b0;
      cyc();
      chk("drop_ovf", overflow_o, 1);
      chk("drop_count", count_o, 6);
      rdy = 1'b1; k = 0;
      for (int i = 0; i < 20 && k < 6; i++) begin
         cyc();
         if (valid_o && ready_i) begin
            chk("full_order", data_o, exp_full[k]);
            k++;
         end
      end
      rdy = 1'b0; cyc();
      chk("full_empty", count_o, 0);
      chk("ovf_sticky", overflow_o, 1);
      rst = 1'b1; #3; rst = 1'b0;
      cyc();
      chk("ovf_cleared", overflow_o, 0);

      // Wrap and ordering with random launches and ready 1,0,0,1
      use_up = 1'b1; up_base = 8'h00; up_cnt = 0; up_lim = 40; k = 0;
      for (int i = 0; i < 2000 && k < 40; i++) begin
         up_want = 1'($urandom_range(0, 1));
         rdy = (i % 4 == 0) || (i % 4 == 3);
         cyc();
         if (valid_o && ready_i) begin
            chk("wrap_data", data_o, 8'(k));
            chk("wrap_status", status_o, st(8'(k)));
            k++;
         end
      end
      chk("wrap_n", k, 40);
      rdy = 1'b0; up_want = 1'b0; use_up = 1'b0;
      cyc();
      chk("wrap_ovf", overflow_o, 0);
      chk("wrap_empty", count_o, 0);

      // Async reset mid-cycle with four entries
      man_v = 1'b1;
      for (int i = 0; i < 4; i++) begin
         man_d = 8'h40 + 8'(i); man_s = st(man_d);
         cyc();
      end
      man_v = 1'b0;
      cyc();
      chk("pre_rst_count", count_o, 4);
      chk("pre_rst_stop", stop_o, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_count", count_o, 0);
      chk("arst_valid", valid_o, 0);
      chk("arst_stop", stop_o, 0);
      #1 rst = 1'b0;
      man_v = 1'b1; man_d = 8'h5A; man_s = 2'b10;
      cyc();
      man_v = 1'b0;
      cyc();
      chk("post_rst_valid", valid_o, 1);
      chk("post_rst_data", data_o, 8'h5A);
      chk("post_rst_status", status_o, 2'b10);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
